// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: operand source encodings,
// load-use FSM state codes and default widths.
package fwd_hazard_unit_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_AW   = 3;
    localparam int DEF_LOAD_LAT = 1;
    localparam int CNT_W        = 3;

    localparam logic [1:0] SEL_RF   = 2'd0;
    localparam logic [1:0] SEL_WB   = 2'd1;
    localparam logic [1:0] SEL_MEM  = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit; master = pipeline,
// slave = the unit itself.
interface fwd_hazard_unit_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              pipe_stall;
    logic              flush;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    logic              f_rs_used;
    logic              f_rt_used;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_rs_used;
    logic              d_rt_used;
    logic [DATA_W-1:0] d_rs_data;
    logic [DATA_W-1:0] d_rt_data;
    logic              d_wr_en;
    logic              d_is_load;
    logic [REG_AW-1:0] d_wr_reg;
    logic              m_wr_en;
    logic [REG_AW-1:0] m_wr_reg;
    logic [DATA_W-1:0] m_data;
    logic              w_wr_en;
    logic [REG_AW-1:0] w_wr_reg;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [1:0]        a_sel;
    logic [1:0]        b_sel;
    logic              hz_stall;
    logic              err;

    modport master (
        output pipe_stall, flush, f_rs, f_rt, f_rs_used, f_rt_used,
               d_rs, d_rt, d_rs_used, d_rt_used, d_rs_data, d_rt_data,
               d_wr_en, d_is_load, d_wr_reg, m_wr_en, m_wr_reg, m_data,
               w_wr_en, w_wr_reg, w_data,
        input  a_data, b_data, a_sel, b_sel, hz_stall, err
    );

    modport slave (
        input  pipe_stall, flush, f_rs, f_rt, f_rs_used, f_rt_used,
               d_rs, d_rt, d_rs_used, d_rt_used, d_rs_data, d_rt_data,
               d_wr_en, d_is_load, d_wr_reg, m_wr_en, m_wr_reg, m_data,
               w_wr_en, w_wr_reg, w_data,
        output a_data, b_data, a_sel, b_sel, hz_stall, err
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_mux.sv
// Per-operand forwarding mux: MEM result beats WB result beats register file.
module fwd_mux
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int ZERO_REG = 0
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic [DATA_W-1:0] rfData,
    input  logic              mWrEn,
    input  logic [REG_AW-1:0] mWrReg,
    input  logic [DATA_W-1:0] mData,
    input  logic              wWrEn,
    input  logic [REG_AW-1:0] wWrReg,
    input  logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        sel
);

    logic isZero;
    logic mHit;
    logic wHit;

    always_comb begin
        isZero = (ZERO_REG != 0) && (src == '0);
        mHit   = used && mWrEn && (mWrReg == src) && !isZero;
        wHit   = used && wWrEn && (wWrReg == src) && !isZero;
        data   = rfData;
        sel    = SEL_RF;
        if (isZero) begin
            data = '0;
            sel  = SEL_RF;
        end else if (mHit) begin
            data = mData;
            sel  = SEL_MEM;
        end else if (wHit) begin
            data = wData;
            sel  = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, memory-stall operand hold and load-use stall generation
// for the execute stage of the 5-stage pipeline.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int ZERO_REG = 0
) (
    input logic             clk,
    input logic             rst,
    fwd_hazard_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic             LAT_BAD  = (LOAD_LAT < 1) || (LOAD_LAT > 7);

    logic [DATA_W-1:0] aFwd;
    logic [DATA_W-1:0] bFwd;
    logic [1:0]        aSelFwd;
    logic [1:0]        bSelFwd;
    logic [DATA_W-1:0] aHold;
    logic [DATA_W-1:0] bHold;
    logic              holdValid;

    logic [0:0]        state;
    logic [0:0]        stateNxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNxt;
    logic              zeroDst;
    logic              rsHit;
    logic              rtHit;
    logic              loadHit;
    logic              detect;
    logic              retrig;
    logic              rstQ;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) uMuxA (
        .src(bus.d_rs), .used(bus.d_rs_used), .rfData(bus.d_rs_data),
        .mWrEn(bus.m_wr_en), .mWrReg(bus.m_wr_reg), .mData(bus.m_data),
        .wWrEn(bus.w_wr_en), .wWrReg(bus.w_wr_reg), .wData(bus.w_data),
        .data(aFwd), .sel(aSelFwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) uMuxB (
        .src(bus.d_rt), .used(bus.d_rt_used), .rfData(bus.d_rt_data),
        .mWrEn(bus.m_wr_en), .mWrReg(bus.m_wr_reg), .mData(bus.m_data),
        .wWrEn(bus.w_wr_en), .wWrReg(bus.w_wr_reg), .wData(bus.w_data),
        .data(bFwd), .sel(bSelFwd)
    );

    // First stalled cycle passes live operands through and captures them;
    // later stalled cycles replay the capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdValid <= 1'b0;
            aHold     <= '0;
            bHold     <= '0;
        end else begin
            holdValid <= bus.pipe_stall;
            if (bus.pipe_stall && !holdValid) begin
                aHold <= aFwd;
                bHold <= bFwd;
            end
        end
    end

    always_comb begin
        if (bus.pipe_stall && holdValid) begin
            bus.a_data = aHold;
            bus.b_data = bHold;
            bus.a_sel  = SEL_HOLD;
            bus.b_sel  = SEL_HOLD;
        end else begin
            bus.a_data = aFwd;
            bus.b_data = bFwd;
            bus.a_sel  = aSelFwd;
            bus.b_sel  = bSelFwd;
        end
    end

    always_comb begin
        zeroDst = (ZERO_REG != 0) && (bus.d_wr_reg == '0);
        rsHit   = bus.f_rs_used && (bus.f_rs == bus.d_wr_reg);
        rtHit   = bus.f_rt_used && (bus.f_rt == bus.d_wr_reg);
        loadHit = bus.d_is_load && bus.d_wr_en && !bus.flush && !zeroDst;
        detect  = loadHit && (rsHit || rtHit);
        retrig  = loadHit && rsHit && rtHit && (state == ST_STALL) && (cnt != '0);
        bus.hz_stall = (state == ST_STALL) || detect;
    end

    // The detect cycle is the first stall cycle, so STALL holds the number of
    // stall cycles still owed (LOAD_LAT-1) and is skipped when that is zero.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        if (bus.flush) begin
            stateNxt = ST_IDLE;
            cntNxt   = '0;
        end else if (!bus.pipe_stall) begin
            if (state == ST_IDLE) begin
                if (detect && (LAT_INIT != '0)) begin
                    stateNxt = ST_STALL;
                    cntNxt   = LAT_INIT;
                end
            end else if (cnt <= CNT_W'(1)) begin
                stateNxt = ST_IDLE;
                cntNxt   = '0;
            end else begin
                cntNxt = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        rstQ <= rst;
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bus.err <= 1'b0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
            if ((bus.d_is_load && !bus.d_wr_en) || (rstQ && LAT_BAD) || retrig) begin
                bus.err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: three instances cover
// ZERO_REG=0/LOAD_LAT=2, ZERO_REG=1/LOAD_LAT=3 and an illegal LOAD_LAT.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.DATA_W(16), .REG_AW(3)) ifc0 ();
    fwd_hazard_unit_if #(.DATA_W(16), .REG_AW(3)) ifc1 ();
    fwd_hazard_unit_if #(.DATA_W(16), .REG_AW(3)) ifc2 ();

    fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .LOAD_LAT(2), .ZERO_REG(0)) u0 (
        .clk(clk), .rst(rst), .bus(ifc0)
    );
    fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .LOAD_LAT(3), .ZERO_REG(1)) u1 (
        .clk(clk), .rst(rst), .bus(ifc1)
    );
    fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .LOAD_LAT(0), .ZERO_REG(0)) u2 (
        .clk(clk), .rst(rst), .bus(ifc2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ifc0.pipe_stall = 0; ifc0.flush = 0; ifc0.f_rs = 0; ifc0.f_rt = 0;
        ifc0.f_rs_used = 0; ifc0.f_rt_used = 0; ifc0.d_rs = 0; ifc0.d_rt = 0;
        ifc0.d_rs_used = 0; ifc0.d_rt_used = 0; ifc0.d_rs_data = 0; ifc0.d_rt_data = 0;
        ifc0.d_wr_en = 0; ifc0.d_is_load = 0; ifc0.d_wr_reg = 0; ifc0.m_wr_en = 0;
        ifc0.m_wr_reg = 0; ifc0.m_data = 0; ifc0.w_wr_en = 0; ifc0.w_wr_reg = 0; ifc0.w_data = 0;
        ifc1.pipe_stall = 0; ifc1.flush = 0; ifc1.f_rs = 0; ifc1.f_rt = 0;
        ifc1.f_rs_used = 0; ifc1.f_rt_used = 0; ifc1.d_rs = 0; ifc1.d_rt = 0;
        ifc1.d_rs_used = 0; ifc1.d_rt_used = 0; ifc1.d_rs_data = 0; ifc1.d_rt_data = 0;
        ifc1.d_wr_en = 0; ifc1.d_is_load = 0; ifc1.d_wr_reg = 0; ifc1.m_wr_en = 0;
        ifc1.m_wr_reg = 0; ifc1.m_data = 0; ifc1.w_wr_en = 0; ifc1.w_wr_reg = 0; ifc1.w_data = 0;
        ifc2.pipe_stall = 0; ifc2.flush = 0; ifc2.f_rs = 0; ifc2.f_rt = 0;
        ifc2.f_rs_used = 0; ifc2.f_rt_used = 0; ifc2.d_rs = 0; ifc2.d_rt = 0;
        ifc2.d_rs_used = 0; ifc2.d_rt_used = 0; ifc2.d_rs_data = 0; ifc2.d_rt_data = 0;
        ifc2.d_wr_en = 0; ifc2.d_is_load = 0; ifc2.d_wr_reg = 0; ifc2.m_wr_en = 0;
        ifc2.m_wr_reg = 0; ifc2.m_data = 0; ifc2.w_wr_en = 0; ifc2.w_wr_reg = 0; ifc2.w_data = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs;
        ifc0.d_rs_data = 16'h0A0A;
        ifc0.d_rt_data = 16'h0B0B;
        repeat (3) tick;
        total++; if (ifc0.a_sel !== 2'd0) begin bad++; $display("FAIL rst_a_sel: got %0d want 0", ifc0.a_sel); end
        total++; if (ifc0.b_sel !== 2'd0) begin bad++; $display("FAIL rst_b_sel: got %0d want 0", ifc0.b_sel); end
        total++; if (ifc0.hz_stall !== 1'b0) begin bad++; $display("FAIL rst_hz: got %b want 0", ifc0.hz_stall); end
        total++; if (ifc0.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", ifc0.err); end
        total++; if (ifc0.a_data !== 16'h0A0A) begin bad++; $display("FAIL rst_a_data: got %h want 0a0a", ifc0.a_data); end
        total++; if (ifc0.b_data !== 16'h0B0B) begin bad++; $display("FAIL rst_b_data: got %h want 0b0b", ifc0.b_data); end
        total++; if (ifc2.err !== 1'b0) begin bad++; $display("FAIL rst_err_badlat: got %b want 0", ifc2.err); end
        rst = 0;
        tick;
        total++; if (ifc2.err !== 1'b1) begin bad++; $display("FAIL badlat_err: got %b want 1", ifc2.err); end
        total++; if (ifc0.err !== 1'b0) begin bad++; $display("FAIL goodlat_err: got %b want 0", ifc0.err); end
    endtask

    task automatic test_forward;
        clear_inputs;
        ifc0.m_wr_en = 1; ifc0.m_wr_reg = 3; ifc0.m_data = 16'h1234;
        ifc0.w_wr_en = 1; ifc0.w_wr_reg = 3; ifc0.w_data = 16'hBEEF;
        ifc0.d_rs = 3; ifc0.d_rs_used = 1; ifc0.d_rs_data = 16'h0A0A;
        #1;
        total++; if (ifc0.a_data !== 16'h1234) begin bad++; $display("FAIL mem_prio_data: got %h want 1234", ifc0.a_data); end
        total++; if (ifc0.a_sel !== 2'd2) begin bad++; $display("FAIL mem_prio_sel: got %0d want 2", ifc0.a_sel); end
        tick;
        clear_inputs;
        ifc0.w_wr_en = 1; ifc0.w_wr_reg = 5; ifc0.w_data = 16'h00AA;
        ifc0.d_rt = 5; ifc0.d_rt_used = 1; ifc0.d_rt_data = 16'h0C0C;
        ifc0.d_rs = 5; ifc0.d_rs_used = 0; ifc0.d_rs_data = 16'h0D0D;
        #1;
        total++; if (ifc0.b_data !== 16'h00AA) begin bad++; $display("FAIL wb_fwd_data: got %h want 00aa", ifc0.b_data); end
        total++; if (ifc0.b_sel !== 2'd1) begin bad++; $display("FAIL wb_fwd_sel: got %0d want 1", ifc0.b_sel); end
        total++; if (ifc0.a_data !== 16'h0D0D) begin bad++; $display("FAIL unused_src_data: got %h want 0d0d", ifc0.a_data); end
        total++; if (ifc0.a_sel !== 2'd0) begin bad++; $display("FAIL unused_src_sel: got %0d want 0", ifc0.a_sel); end
        tick;
    endtask

    task automatic test_zero_reg;
        clear_inputs;
        ifc1.d_rs = 0; ifc1.d_rs_used = 1; ifc1.d_rs_data = 16'h1111;
        ifc1.m_wr_en = 1; ifc1.m_wr_reg = 0; ifc1.m_data = 16'h7777;
        ifc0.d_rs = 0; ifc0.d_rs_used = 1; ifc0.d_rs_data = 16'h1111;
        ifc0.m_wr_en = 1; ifc0.m_wr_reg = 0; ifc0.m_data = 16'h7777;
        ifc1.d_is_load = 1; ifc1.d_wr_en = 1; ifc1.d_wr_reg = 0;
        ifc1.f_rs = 0; ifc1.f_rs_used = 1;
        #1;
        total++; if (ifc1.a_data !== 16'h0000) begin bad++; $display("FAIL zreg_data: got %h want 0000", ifc1.a_data); end
        total++; if (ifc1.a_sel !== 2'd0) begin bad++; $display("FAIL zreg_sel: got %0d want 0", ifc1.a_sel); end
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL zreg_no_hz: got %b want 0", ifc1.hz_stall); end
        total++; if (ifc0.a_data !== 16'h7777) begin bad++; $display("FAIL r0_fwd_data: got %h want 7777", ifc0.a_data); end
        total++; if (ifc0.a_sel !== 2'd2) begin bad++; $display("FAIL r0_fwd_sel: got %0d want 2", ifc0.a_sel); end
        tick;
        clear_inputs;
        tick;
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL zreg_no_stall_after: got %b want 0", ifc1.hz_stall); end
    endtask

    task automatic test_load_use;
        clear_inputs;
        ifc0.d_is_load = 1; ifc0.d_wr_en = 1; ifc0.d_wr_reg = 2;
        ifc0.f_rs = 4; ifc0.f_rs_used = 1;
        #1;
        total++; if (ifc0.hz_stall !== 1'b0) begin bad++; $display("FAIL lu_nomatch: got %b want 0", ifc0.hz_stall); end
        ifc0.f_rs = 2;
        #1;
        total++; if (ifc0.hz_stall !== 1'b1) begin bad++; $display("FAIL lu_cyc1: got %b want 1", ifc0.hz_stall); end
        tick;
        ifc0.d_is_load = 0; ifc0.d_wr_en = 0;
        #1;
        total++; if (ifc0.hz_stall !== 1'b1) begin bad++; $display("FAIL lu_cyc2: got %b want 1", ifc0.hz_stall); end
        tick;
        total++; if (ifc0.hz_stall !== 1'b0) begin bad++; $display("FAIL lu_cyc3: got %b want 0", ifc0.hz_stall); end
        tick;
        total++; if (ifc0.hz_stall !== 1'b0) begin bad++; $display("FAIL lu_cyc4: got %b want 0", ifc0.hz_stall); end
    endtask

    task automatic test_hold;
        clear_inputs;
        ifc0.m_wr_en = 1; ifc0.m_wr_reg = 3; ifc0.m_data = 16'h5555;
        ifc0.d_rs = 3; ifc0.d_rs_used = 1; ifc0.d_rs_data = 16'h0A0A;
        ifc0.pipe_stall = 1;
        #1;
        total++; if (ifc0.a_data !== 16'h5555 || ifc0.a_sel !== 2'd2) begin
            bad++; $display("FAIL hold_c1: got %h/%0d want 5555/2", ifc0.a_data, ifc0.a_sel); end
        tick;
        ifc0.m_data = 16'h0000;
        #1;
        total++; if (ifc0.a_data !== 16'h5555 || ifc0.a_sel !== 2'd3) begin
            bad++; $display("FAIL hold_c2: got %h/%0d want 5555/3", ifc0.a_data, ifc0.a_sel); end
        tick;
        total++; if (ifc0.a_data !== 16'h5555 || ifc0.a_sel !== 2'd3) begin
            bad++; $display("FAIL hold_c3: got %h/%0d want 5555/3", ifc0.a_data, ifc0.a_sel); end
        ifc0.pipe_stall = 0;
        #1;
        total++; if (ifc0.a_data !== 16'h0000 || ifc0.a_sel !== 2'd2) begin
            bad++; $display("FAIL hold_release: got %h/%0d want 0000/2", ifc0.a_data, ifc0.a_sel); end
        tick;
    endtask

    task automatic test_flush;
        clear_inputs;
        ifc1.d_is_load = 1; ifc1.d_wr_en = 1; ifc1.d_wr_reg = 2;
        ifc1.f_rs = 2; ifc1.f_rs_used = 1;
        #1;
        total++; if (ifc1.hz_stall !== 1'b1) begin bad++; $display("FAIL fl_cyc1: got %b want 1", ifc1.hz_stall); end
        tick;
        ifc1.d_is_load = 0; ifc1.d_wr_en = 0; ifc1.flush = 1;
        #1;
        total++; if (ifc1.hz_stall !== 1'b1) begin bad++; $display("FAIL fl_cyc2: got %b want 1", ifc1.hz_stall); end
        tick;
        ifc1.flush = 0;
        #1;
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL fl_cyc3: got %b want 0", ifc1.hz_stall); end
        tick;
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL fl_cyc4: got %b want 0", ifc1.hz_stall); end
    endtask

    task automatic test_freeze;
        logic expHz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic stallIn [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_inputs;
        ifc1.d_is_load = 1; ifc1.d_wr_en = 1; ifc1.d_wr_reg = 6;
        ifc1.f_rt = 6; ifc1.f_rt_used = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                ifc1.d_is_load = 0; ifc1.d_wr_en = 0;
            end
            ifc1.pipe_stall = stallIn[i];
            #1;
            total++; if (ifc1.hz_stall !== expHz[i]) begin
                bad++; $display("FAIL freeze_cyc%0d: got %b want %b", i + 1, ifc1.hz_stall, expHz[i]); end
            tick;
        end
    endtask

    task automatic test_err;
        clear_inputs;
        ifc0.d_is_load = 1; ifc0.d_wr_en = 0; ifc0.d_wr_reg = 2;
        ifc0.f_rs = 2; ifc0.f_rs_used = 1;
        #1;
        total++; if (ifc0.err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", ifc0.err); end
        total++; if (ifc0.hz_stall !== 1'b0) begin bad++; $display("FAIL err_no_hz: got %b want 0", ifc0.hz_stall); end
        tick;
        clear_inputs;
        total++; if (ifc0.err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", ifc0.err); end
        repeat (3) tick;
        total++; if (ifc0.err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", ifc0.err); end
        do_reset;
        total++; if (ifc0.err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", ifc0.err); end
    endtask

    task automatic test_retrigger;
        clear_inputs;
        ifc0.d_is_load = 1; ifc0.d_wr_en = 1; ifc0.d_wr_reg = 2;
        ifc0.f_rs = 2; ifc0.f_rs_used = 1; ifc0.f_rt = 2; ifc0.f_rt_used = 1;
        #1;
        total++; if (ifc0.hz_stall !== 1'b1) begin bad++; $display("FAIL rt_hz: got %b want 1", ifc0.hz_stall); end
        tick;
        total++; if (ifc0.err !== 1'b0) begin bad++; $display("FAIL rt_err_pre: got %b want 0", ifc0.err); end
        tick;
        total++; if (ifc0.err !== 1'b1) begin bad++; $display("FAIL rt_err_set: got %b want 1", ifc0.err); end
        clear_inputs;
        do_reset;
    endtask

    task automatic test_rst_mid_stall;
        clear_inputs;
        ifc1.d_is_load = 1; ifc1.d_wr_en = 1; ifc1.d_wr_reg = 2;
        ifc1.f_rs = 2; ifc1.f_rs_used = 1;
        ifc1.d_rs = 3; ifc1.d_rs_used = 1; ifc1.m_wr_en = 1; ifc1.m_wr_reg = 3; ifc1.m_data = 16'h4242;
        tick;
        ifc1.d_is_load = 0; ifc1.d_wr_en = 0; ifc1.pipe_stall = 1;
        #1;
        total++; if (ifc1.hz_stall !== 1'b1) begin bad++; $display("FAIL rm_stall: got %b want 1", ifc1.hz_stall); end
        tick;
        total++; if (ifc1.a_sel !== 2'd3) begin bad++; $display("FAIL rm_held: got %0d want 3", ifc1.a_sel); end
        rst = 1;
        ifc1.m_data = 16'h2424;
        tick;
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL rm_hz_cleared: got %b want 0", ifc1.hz_stall); end
        total++; if (ifc1.a_sel !== 2'd2 || ifc1.a_data !== 16'h2424) begin
            bad++; $display("FAIL rm_hold_cleared: got %0d/%h want 2/2424", ifc1.a_sel, ifc1.a_data); end
        rst = 0;
        ifc1.pipe_stall = 0;
        tick;
        total++; if (ifc1.hz_stall !== 1'b0) begin bad++; $display("FAIL rm_idle: got %b want 0", ifc1.hz_stall); end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_zero_reg;
        test_load_use;
        test_hold;
        test_flush;
        test_freeze;
        test_err;
        test_retrigger;
        test_rst_mid_stall;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
